debounce_filter: RTL and testbench

//  Conditions a raw, asynchronous, bouncy input (push-button/switch) into a clean

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_filter_sync_ff.sv | 28 ++
 rtl/debounce_filter.sv | 113 +++++++++++
 tb/tb_debounce_filter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default parameter values for the debounce filter.
// The state encoding is visible to anything that probes the filter's FSM.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int DB_STABLE_DEFAULT = 4;
    localparam int DB_SYNC_DEFAULT   = 2;

endpackage : debounce_pkg

// File: rtl/debounce_filter_sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
// Standalone so other blocks can reuse it.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be >= 2");
    end

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/debounce_filter.sv
// Debounces a bouncy asynchronous input into a clean level; pending transitions
// that are aborted before STABLE_CYCLES equal samples raise a one-cycle glitch flag.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_DEFAULT,
    parameter int SYNC_STAGES   = DB_SYNC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic x_out,
    output logic busy,
    output logic glitch
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_filter: STABLE_CYCLES must be >= 2");
    end

    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             glitch_q, glitch_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE_LOW;
            cnt_q    <= '0;
            x_q      <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            glitch_q <= glitch_d;
        end
    end

    // The first differing sample already counts as 1, so acceptance happens
    // when the STABLE_CYCLES-th consecutive sample arrives with cnt at its max.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        glitch_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d  = IDLE_LOW;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = IDLE_HIGH;
                    x_d      = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d  = IDLE_HIGH;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = IDLE_LOW;
                    x_d      = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign x_out  = x_q;
    assign glitch = glitch_q;
    assign busy   = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule : debounce_filter

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: a hand-derived per-edge vector table run through a
// scoreboard queue, plus a STABLE_CYCLES=2 latency rerun and event-count checks.
module tb_debounce_filter;
    import debounce_pkg::*;

    typedef struct packed {
        logic rst;
        logic raw;
        logic x;
        logic busy;
        logic glitch;
    } vec_t;

    typedef struct packed {
        logic x;
        logic busy;
        logic glitch;
    } exp_t;

    logic clk = 1'b0;
    logic rst, raw, x_out, busy, glitch;
    logic rst2, raw2, x_out2, busy2, glitch2;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   rises  = 0;
    int   glitches = 0;
    logic prev_x = 1'b0;

    always #5 clk = ~clk;

    debounce_filter dut (
        .clk    (clk),
        .reset  (rst),
        .raw_in (raw),
        .x_out  (x_out),
        .busy   (busy),
        .glitch (glitch)
    );

    debounce_filter #(.STABLE_CYCLES(2)) dut2 (
        .clk    (clk),
        .reset  (rst2),
        .raw_in (raw2),
        .x_out  (x_out2),
        .busy   (busy2),
        .glitch (glitch2)
    );

    task automatic add(input int n, input logic r, input logic rw,
                       input logic ex, input logic eb, input logic eg);
        for (int k = 0; k < n; k++) vecs.push_back('{r, rw, ex, eb, eg});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b1; raw = 1'b1; rst2 = 1'b1; raw2 = 1'b0;

        // reset with raw_in high, then settle low
        add(2, 1, 1, 0, 0, 0);
        add(2, 0, 0, 0, 0, 0);
        // clean rise: busy after edges 3..5, x_out after edge 6
        add(2, 0, 1, 0, 0, 0);
        add(3, 0, 1, 0, 1, 0);
        add(2, 0, 1, 1, 0, 0);
        // clean fall
        add(2, 0, 0, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0);
        add(2, 0, 0, 0, 0, 0);
        // bounce: 1,1,0 then 1 held
        add(2, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 1, 0);
        add(1, 0, 1, 0, 0, 1);
        add(3, 0, 1, 0, 1, 0);
        add(2, 0, 1, 1, 0, 0);
        // fall back
        add(2, 0, 0, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0);
        // short pulse of 3 cycles
        add(2, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0);
        add(2, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1);
        add(2, 0, 0, 0, 0, 0);
        // rise, then fall interrupted by reset in WAIT_LOW (index 52)
        add(2, 0, 1, 0, 0, 0);
        add(3, 0, 1, 0, 1, 0);
        add(2, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0, 0);
        // full rise after reset
        add(2, 0, 1, 0, 0, 0);
        add(3, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 0);
        // fall, rise, reset on the edge that would set x_out (index 72)
        add(2, 0, 0, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0);
        add(3, 0, 1, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            raw = vecs[i].raw;
            sb.push_back('{vecs[i].x, vecs[i].busy, vecs[i].glitch});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d {x,busy,glitch}", i),
                  {29'd0, x_out, busy, glitch}, {29'd0, e.x, e.busy, e.glitch});
            if (x_out && !prev_x) rises++;
            if (glitch) glitches++;
            prev_x = x_out;
            if (i == 52) begin
                check("reset_state", 32'(dut.state_q), 32'(IDLE_LOW));
                check("reset_cnt", 32'(dut.cnt_q), 32'd0);
            end
        end
        check("x_out rising edges (downstream y pulses)", rises, 4);
        check("glitch pulses", glitches, 2);

        // STABLE_CYCLES=2 rerun: x_out on edge 4 after raw_in rises
        @(negedge clk); rst2 = 1'b1; raw2 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst2 = 1'b0; raw2 = 1'b1;
        for (int ed = 1; ed <= 5; ed++) begin
            sb.push_back('{(ed >= 4), (ed == 3), 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("sc2 edge%0d {x,busy,glitch}", ed),
                  {29'd0, x_out2, busy2, glitch2}, {29'd0, e.x, e.busy, e.glitch});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_debounce_filter
